// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit common-anode seven-segment driver
// Optional leading-zero suppression enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] data1,
    input  logic [3:0] data2,
    input  logic [3:0] data3,
    input  logic [3:0] data4,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] LP_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_snap [4];
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_frame_tick;

    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_suppress;
    logic [3:0]       w_digit;
    logic [3:0]       w_an_sel;
    logic [3:0]       w_an_next;
    logic [6:0]       w_seg_next;

    // Active-low gfedcba patterns for a common-anode display.
    function automatic logic [6:0] f_hex7(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'h0: v = 7'b1000000;
            4'h1: v = 7'b1111001;
            4'h2: v = 7'b0100100;
            4'h3: v = 7'b0110000;
            4'h4: v = 7'b0011001;
            4'h5: v = 7'b0010010;
            4'h6: v = 7'b0000010;
            4'h7: v = 7'b1111000;
            4'h8: v = 7'b0000000;
            4'h9: v = 7'b0010000;
            4'hA: v = 7'b0001000;
            4'hB: v = 7'b0000011;
            4'hC: v = 7'b1000110;
            4'hD: v = 7'b0100001;
            4'hE: v = 7'b0000110;
            default: v = 7'b0001110;
        endcase
        return v;
    endfunction

    assign w_slot_end  = (r_cnt == LP_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);
    assign w_digit     = r_snap[r_idx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit goes dark when it and everything to its left are zero; the rightmost always shows.
    always_comb begin
        w_suppress = 1'b0;
        case (r_idx)
            2'd0:    w_suppress = (r_snap[0] == 4'h0);
            2'd1:    w_suppress = (r_snap[0] == 4'h0) && (r_snap[1] == 4'h0);
            2'd2:    w_suppress = (r_snap[0] == 4'h0) && (r_snap[1] == 4'h0)
                                  && (r_snap[2] == 4'h0);
            default: w_suppress = 1'b0;
        endcase
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_comb begin
        w_an_sel = 4'b1111;
        case (r_idx)
            2'd0:    w_an_sel = 4'b0111;
            2'd1:    w_an_sel = 4'b1011;
            2'd2:    w_an_sel = 4'b1101;
            default: w_an_sel = 4'b1110;
        endcase
    end

    // Blanking gap at slot start keeps the previous digit from ghosting onto the next anode.
    always_comb begin
        w_an_next = 4'b1111;
        if (en && (r_cnt >= LP_BLANK) && !w_suppress) begin
            w_an_next = w_an_sel;
        end
        w_seg_next = f_hex7(w_digit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_snap[0]    <= 4'h0;
            r_snap[1]    <= 4'h0;
            r_snap[2]    <= 4'h0;
            r_snap[3]    <= 4'h0;
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Whole-frame snapshot so a mid-frame data update never tears the display.
            if (w_frame_end) begin
                r_snap[0] <= data1;
                r_snap[1] <= data2;
                r_snap[2] <= data3;
                r_snap[3] <= data4;
            end
            r_frame_tick <= w_frame_end;
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [3:0] data1 = 4'h0;
    logic [3:0] data2 = 4'h0;
    logic [3:0] data3 = 4'h0;
    logic [3:0] data4 = 4'h0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .en(en),
        .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // e = edge index within the frame (0..31); pre-edge cnt = e%8, idx = e/8
    function automatic logic [3:0] exp_an(int e, logic en_s, logic vis);
        return (en_s && vis && (e % 8) >= 2) ? an_tab[e / 8] : 4'b1111;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        data1 = 4'h1; data2 = 4'h2; data3 = 4'h3; data4 = 4'h4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: an=%b seg=%b dp=%b ft=%b, want 1111 1111111 1 0",
                         i, an, seg, dp, frame_tick);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        for (int e = 0; e < 32; e++) begin
            tick();
            checks++;
            if (an !== exp_an(e, 1'b1, 1'b1) || seg !== seg_tab[0] || frame_tick !== (e == 31)) begin
                errors++;
                $display("FAIL first_frame e%0d: an=%b seg=%b ft=%b, want %b %b %b",
                         e, an, seg, frame_tick, exp_an(e, 1'b1, 1'b1), seg_tab[0], (e == 31));
            end
        end
    endtask

    task automatic test_snapshot_hold();
        logic [3:0] disp [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int e = 0; e < 32; e++) begin
            if (e == 3) data1 = 4'h8;
            tick();
            checks++;
            if (an !== exp_an(e, 1'b1, 1'b1) || seg !== seg_tab[disp[e / 8]]
                || frame_tick !== (e == 31)) begin
                errors++;
                $display("FAIL snapshot_hold e%0d: an=%b seg=%b ft=%b, want %b %b %b",
                         e, an, seg, frame_tick, exp_an(e, 1'b1, 1'b1), seg_tab[disp[e / 8]], (e == 31));
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] disp [4] = '{4'h8, 4'h2, 4'h3, 4'h4};
        for (int e = 0; e < 32; e++) begin
            en = !(e >= 5 && e < 25);
            tick();
            checks++;
            if (an !== exp_an(e, en, 1'b1) || seg !== seg_tab[disp[e / 8]]
                || frame_tick !== (e == 31)) begin
                errors++;
                $display("FAIL enable e%0d: an=%b seg=%b ft=%b, want %b %b %b",
                         e, an, seg, frame_tick, exp_an(e, en, 1'b1), seg_tab[disp[e / 8]], (e == 31));
            end
        end
        en = 1'b1;
    endtask

    task automatic test_hex_decode();
        logic [15:0] sets [4] = '{16'h5679, 16'hABCD, 16'hEF01, 16'h0000};
        logic [15:0] shown = 16'h8234;
        logic [3:0]  d;
        for (int k = 0; k < 4; k++) begin
            {data1, data2, data3, data4} = sets[k];
            for (int e = 0; e < 32; e++) begin
                tick();
                d = shown[15 - 4 * (e / 8) -: 4];
                checks++;
                if (an !== exp_an(e, 1'b1, 1'b1) || seg !== seg_tab[d] || frame_tick !== (e == 31)) begin
                    errors++;
                    $display("FAIL hex_decode set%0d e%0d: an=%b seg=%b ft=%b, want %b %b %b",
                             k, e, an, seg, frame_tick, exp_an(e, 1'b1, 1'b1), seg_tab[d], (e == 31));
                end
            end
            shown = sets[k];
        end
    endtask

    task automatic test_reset_mid_slot();
        data1 = 4'h9; data2 = 4'h9; data3 = 4'h9; data4 = 4'h9;
        repeat (32) tick();
        repeat (21) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_slot: an=%b seg=%b ft=%b, want 1111 1111111 0", an, seg, frame_tick);
        end
        reset = 1'b0;
        for (int e = 0; e < 32; e++) begin
            tick();
            checks++;
            if (an !== exp_an(e, 1'b1, 1'b1) || seg !== seg_tab[0] || frame_tick !== (e == 31)) begin
                errors++;
                $display("FAIL reset_restart e%0d: an=%b seg=%b ft=%b, want %b %b %b",
                         e, an, seg, frame_tick, exp_an(e, 1'b1, 1'b1), seg_tab[0], (e == 31));
            end
        end
        tick();
        checks++;
        if (seg !== seg_tab[9]) begin
            errors++;
            $display("FAIL reset_reload: seg=%b, want %b", seg, seg_tab[9]);
        end
        repeat (31) tick();
    endtask

    task automatic test_leading_zero();
        logic [15:0] sets [2] = '{16'h0000, 16'h00A0};
        logic [3:0]  vis  [2];
        logic [3:0]  d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vis[0] = 4'b0001;
        vis[1] = 4'b0011;
`else
        vis[0] = 4'b1111;
        vis[1] = 4'b1111;
`endif
        {data1, data2, data3, data4} = sets[0];
        repeat (32) tick();
        for (int k = 0; k < 2; k++) begin
            {data1, data2, data3, data4} = sets[(k + 1) % 2];
            for (int e = 0; e < 32; e++) begin
                tick();
                d = sets[k][15 - 4 * (e / 8) -: 4];
                checks++;
                if (an !== exp_an(e, 1'b1, vis[k][3 - e / 8]) || seg !== seg_tab[d]) begin
                    errors++;
                    $display("FAIL leading_zero set%0d e%0d: an=%b seg=%b, want %b %b",
                             k, e, an, seg, exp_an(e, 1'b1, vis[k][3 - e / 8]), seg_tab[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_snapshot_hold();
        test_enable();
        test_hex_decode();
        test_reset_mid_slot();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
